// File: rtl/tag_lookup_ctrl_if.sv
// rtl/tag_lookup_ctrl_if.sv - request, response, flush and tag-RAM signal bundle for tag_lookup_ctrl
interface tag_lookup_ctrl_if #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 14
);
  localparam int TWIDTH = DWIDTH - 1;

  logic                     req_valid;
  logic                     req_ready;
  logic [TWIDTH+AWIDTH-1:0] req_addr;
  logic                     req_alloc;

  logic                     rsp_valid;
  logic                     rsp_hit;
  logic [AWIDTH-1:0]        rsp_index;
  logic                     rsp_victim_valid;
  logic [TWIDTH-1:0]        rsp_victim_tag;

  logic                     flush_req;
  logic                     flush_busy;
  logic                     flush_done;

  logic [AWIDTH-1:0]        ram_addr;
  logic [DWIDTH-1:0]        ram_din;
  logic                     ram_we;
  logic [DWIDTH-1:0]        ram_dout;

  modport slave (
    input  req_valid, req_addr, req_alloc, flush_req, ram_dout,
    output req_ready, rsp_valid, rsp_hit, rsp_index, rsp_victim_valid, rsp_victim_tag,
    output flush_busy, flush_done, ram_addr, ram_din, ram_we
  );

  modport master (
    output req_valid, req_addr, req_alloc, flush_req, ram_dout,
    input  req_ready, rsp_valid, rsp_hit, rsp_index, rsp_victim_valid, rsp_victim_tag,
    input  flush_busy, flush_done, ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/tag_lookup_ctrl.sv
// rtl/tag_lookup_ctrl.sv - tag lookup/allocate controller with flush sequencer (optional TAG_LOOKUP_STATS_EN hit/miss counters)
module tag_lookup_ctrl #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 14
) (
  input  logic               clock,
  input  logic               reset_n,
  tag_lookup_ctrl_if.slave   bus
`ifdef TAG_LOOKUP_STATS_EN
  ,
  output logic [15:0]        hit_count,
  output logic [15:0]        miss_count
`endif
);
  localparam int TWIDTH = DWIDTH - 1;
  localparam int DEPTH  = 1 << AWIDTH;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_COMPARE, S_FILL, S_FLUSH} state_t;

  state_t              state_q, state_d;
  logic [TWIDTH-1:0]   tag_q, tag_d;
  logic [AWIDTH-1:0]   index_q, index_d;
  logic                alloc_q, alloc_d;
  logic [AWIDTH-1:0]   flush_cnt_q, flush_cnt_d;
  logic                flush_done_q, flush_done_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_hit_q, rsp_hit_d;
  logic [AWIDTH-1:0]   rsp_index_q, rsp_index_d;
  logic                rsp_vv_q, rsp_vv_d;
  logic [TWIDTH-1:0]   rsp_vt_q, rsp_vt_d;
  // Victim staged at COMPARE so the visible response fields only change when a response is issued
  logic                vic_valid_q, vic_valid_d;
  logic [TWIDTH-1:0]   vic_tag_q, vic_tag_d;

  logic                req_ready_c;
  logic                flush_busy_c;
  logic                ram_we_c;
  logic [AWIDTH-1:0]   ram_addr_c;
  logic [DWIDTH-1:0]   ram_din_c;
  logic                hit_c;

  assign hit_c = bus.ram_dout[DWIDTH-1] & (bus.ram_dout[TWIDTH-1:0] == tag_q);

  // Next-state, request capture, response formation and tag-RAM drive
  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    index_d      = index_q;
    alloc_d      = alloc_q;
    flush_cnt_d  = flush_cnt_q;
    flush_done_d = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_hit_d    = rsp_hit_q;
    rsp_index_d  = rsp_index_q;
    rsp_vv_d     = rsp_vv_q;
    rsp_vt_d     = rsp_vt_q;
    vic_valid_d  = vic_valid_q;
    vic_tag_d    = vic_tag_q;
    req_ready_c  = 1'b0;
    flush_busy_c = 1'b0;
    ram_we_c     = 1'b0;
    ram_addr_c   = '0;
    ram_din_c    = '0;
    case (state_q)
      S_IDLE: begin
        req_ready_c = 1'b1;
        if (bus.flush_req) begin
          req_ready_c = 1'b0;
          flush_cnt_d = '0;
          state_d     = S_FLUSH;
        end else if (bus.req_valid) begin
          tag_d   = bus.req_addr[TWIDTH+AWIDTH-1:AWIDTH];
          index_d = bus.req_addr[AWIDTH-1:0];
          alloc_d = bus.req_alloc;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        ram_addr_c = index_q;
        state_d    = S_COMPARE;
      end
      S_COMPARE: begin
        ram_addr_c  = index_q;
        vic_valid_d = bus.ram_dout[DWIDTH-1];
        vic_tag_d   = bus.ram_dout[TWIDTH-1:0];
        if (hit_c || !alloc_q) begin
          rsp_valid_d = 1'b1;
          rsp_hit_d   = hit_c;
          rsp_index_d = index_q;
          rsp_vv_d    = bus.ram_dout[DWIDTH-1];
          rsp_vt_d    = bus.ram_dout[TWIDTH-1:0];
          state_d     = S_IDLE;
        end else begin
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        ram_we_c    = 1'b1;
        ram_addr_c  = index_q;
        ram_din_c   = {1'b1, tag_q};
        rsp_valid_d = 1'b1;
        rsp_hit_d   = 1'b0;
        rsp_index_d = index_q;
        rsp_vv_d    = vic_valid_q;
        rsp_vt_d    = vic_tag_q;
        state_d     = S_IDLE;
      end
      S_FLUSH: begin
        flush_busy_c = 1'b1;
        ram_we_c     = 1'b1;
        ram_addr_c   = flush_cnt_q;
        ram_din_c    = '0;
        if (flush_cnt_q == AWIDTH'(DEPTH - 1)) begin
          flush_cnt_d  = '0;
          flush_done_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q + AWIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, request and response registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      tag_q        <= '0;
      index_q      <= '0;
      alloc_q      <= 1'b0;
      flush_cnt_q  <= '0;
      flush_done_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_hit_q    <= 1'b0;
      rsp_index_q  <= '0;
      rsp_vv_q     <= 1'b0;
      rsp_vt_q     <= '0;
      vic_valid_q  <= 1'b0;
      vic_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      index_q      <= index_d;
      alloc_q      <= alloc_d;
      flush_cnt_q  <= flush_cnt_d;
      flush_done_q <= flush_done_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_hit_q    <= rsp_hit_d;
      rsp_index_q  <= rsp_index_d;
      rsp_vv_q     <= rsp_vv_d;
      rsp_vt_q     <= rsp_vt_d;
      vic_valid_q  <= vic_valid_d;
      vic_tag_q    <= vic_tag_d;
    end
  end

  assign bus.req_ready        = req_ready_c;
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_hit          = rsp_hit_q;
  assign bus.rsp_index        = rsp_index_q;
  assign bus.rsp_victim_valid = rsp_vv_q;
  assign bus.rsp_victim_tag   = rsp_vt_q;
  assign bus.flush_busy       = flush_busy_c;
  assign bus.flush_done       = flush_done_q;
  assign bus.ram_addr         = ram_addr_c;
  assign bus.ram_din          = ram_din_c;
  assign bus.ram_we           = ram_we_c;

`ifdef TAG_LOOKUP_STATS_EN
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;

  // Saturating hit/miss counters, cleared when a flush starts
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == S_IDLE && bus.flush_req) begin
      hit_count_d  = '0;
      miss_count_d = '0;
    end else if (rsp_valid_d) begin
      if (rsp_hit_d) begin
        if (hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
      end else begin
        if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif
endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// tb/tb_tag_lookup_ctrl.sv - self-checking bench for tag_lookup_ctrl against a cycle-scheduled transaction model
module tb_tag_lookup_ctrl;
  localparam int AW = 3;
  localparam int DW = 14;
  localparam int TW = 13;
  localparam int DEPTH = 8;
  localparam int MAXC = 8192;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  tag_lookup_ctrl_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();
`ifdef TAG_LOOKUP_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  tag_lookup_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef TAG_LOOKUP_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  // Synchronous-read tag RAM, loaded with random contents on the first edge
  logic [DW-1:0] init_val [DEPTH];
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] ram_dout_q;
  bit ram_loaded;
  assign bus.ram_dout = ram_dout_q;
  always @(posedge clock) begin
    if (!ram_loaded) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_val[i];
      ram_loaded <= 1'b1;
    end else begin
      if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_din;
      ram_dout_q <= ram[bus.ram_addr];
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle expectation schedule filled in when the model accepts an operation
  bit            e_we [MAXC];
  logic [AW-1:0] e_addr [MAXC];
  logic [DW-1:0] e_din [MAXC];
  bit            e_chk_addr [MAXC];
  bit            e_chk_din [MAXC];
  bit            e_rv [MAXC];
  bit            e_hit [MAXC];
  logic [AW-1:0] e_idx [MAXC];
  bit            e_vv [MAXC];
  logic [TW-1:0] e_vt [MAXC];
  bit            e_busy [MAXC];
  bit            e_done [MAXC];
  bit            e_fl_entry [MAXC];

  logic [DW-1:0] mem_m [DEPTH];
  int            idle_from;
  logic          l_hit, l_vv;
  logic [AW-1:0] l_idx;
  logic [TW-1:0] l_vt;
  int            m_hits, m_misses;

  task automatic clear_from(input int t0);
    for (int k = t0; k < MAXC; k++) begin
      e_we[k] = 0; e_addr[k] = '0; e_din[k] = '0; e_chk_addr[k] = 1; e_chk_din[k] = 1;
      e_rv[k] = 0; e_hit[k] = 0; e_idx[k] = '0; e_vv[k] = 0; e_vt[k] = '0;
      e_busy[k] = 0; e_done[k] = 0; e_fl_entry[k] = 0;
    end
  endtask

  // Model and the single per-cycle compare process
  initial begin
    int t;
    logic [TW-1:0] tg;
    logic [AW-1:0] ix;
    logic [DW-1:0] ent;
    logic h;
    int r;
    for (int i = 0; i < DEPTH; i++) begin
      init_val[i] = DW'($urandom);
      mem_m[i] = init_val[i];
    end
    clear_from(0);
    idle_from = 0;
    l_hit = 0; l_vv = 0; l_idx = '0; l_vt = '0;
    m_hits = 0; m_misses = 0;
    forever begin
      @(negedge clock);
      t = cyc;
      if (t + 12 >= MAXC) continue;
      if (!reset_n) begin
        clear_from(t);
        idle_from = t;
        l_hit = 0; l_vv = 0; l_idx = '0; l_vt = '0;
        m_hits = 0; m_misses = 0;
      end
      if (e_we[t]) mem_m[e_addr[t]] = e_din[t];
      if (e_fl_entry[t]) begin m_hits = 0; m_misses = 0; end
      if (e_rv[t]) begin
        l_hit = e_hit[t]; l_idx = e_idx[t]; l_vv = e_vv[t]; l_vt = e_vt[t];
        if (e_hit[t]) begin if (m_hits < 65535) m_hits++; end
        else begin if (m_misses < 65535) m_misses++; end
      end
      chk("req_ready", bus.req_ready, (t >= idle_from) && !bus.flush_req);
      chk("ram_we", bus.ram_we, e_we[t]);
      if (e_chk_addr[t]) chk("ram_addr", bus.ram_addr, e_addr[t]);
      if (e_chk_din[t]) chk("ram_din", bus.ram_din, e_din[t]);
      chk("rsp_valid", bus.rsp_valid, e_rv[t]);
      chk("rsp_hit", bus.rsp_hit, l_hit);
      chk("rsp_index", bus.rsp_index, l_idx);
      chk("rsp_victim_valid", bus.rsp_victim_valid, l_vv);
      chk("rsp_victim_tag", bus.rsp_victim_tag, l_vt);
      chk("flush_busy", bus.flush_busy, e_busy[t]);
      chk("flush_done", bus.flush_done, e_done[t]);
`ifdef TAG_LOOKUP_STATS_EN
      chk("hit_count", hit_count, m_hits);
      chk("miss_count", miss_count, m_misses);
`endif
      if (reset_n && t >= idle_from) begin
        if (bus.flush_req) begin
          for (int i = 0; i < DEPTH; i++) begin
            e_we[t+1+i] = 1; e_addr[t+1+i] = AW'(i); e_din[t+1+i] = '0; e_busy[t+1+i] = 1;
          end
          e_done[t+1+DEPTH] = 1;
          e_fl_entry[t+1] = 1;
          idle_from = t + 1 + DEPTH;
        end else if (bus.req_valid) begin
          tg = bus.req_addr[TW+AW-1:AW];
          ix = bus.req_addr[AW-1:0];
          ent = mem_m[ix];
          h = ent[DW-1] && (ent[TW-1:0] == tg);
          e_addr[t+1] = ix; e_chk_din[t+1] = 0;
          e_chk_addr[t+2] = 0; e_chk_din[t+2] = 0;
          if (!h && bus.req_alloc) begin
            e_we[t+3] = 1; e_addr[t+3] = ix; e_din[t+3] = {1'b1, tg};
            r = t + 4;
          end else begin
            r = t + 3;
          end
          e_rv[r] = 1; e_hit[r] = h; e_idx[r] = ix; e_vv[r] = ent[DW-1]; e_vt[r] = ent[TW-1:0];
          idle_from = r;
        end
      end
    end
  end

  int wr_cnt = 0;
  int done_cnt = 0;
  always @(negedge clock) begin
    if (bus.ram_we) wr_cnt <= wr_cnt + 1;
    if (bus.flush_done) done_cnt <= done_cnt + 1;
  end

  int r_lat;
  logic r_hit, r_vv, r_we3;
  logic [AW-1:0] r_idx, r_a3;
  logic [TW-1:0] r_vt;
  logic [DW-1:0] r_din3;

  task automatic wait_rsp();
    r_lat = 0; r_we3 = 0; r_a3 = '0; r_din3 = '0;
    do begin
      @(negedge clock);
      r_lat++;
      if (r_lat == 3) begin r_we3 = bus.ram_we; r_a3 = bus.ram_addr; r_din3 = bus.ram_din; end
    end while (!bus.rsp_valid && r_lat < 10);
    chk("rsp_arrives", bus.rsp_valid, 1);
    r_hit = bus.rsp_hit; r_idx = bus.rsp_index; r_vv = bus.rsp_victim_valid; r_vt = bus.rsp_victim_tag;
  endtask

  task automatic do_req(input logic [15:0] addr, input logic alloc);
    int k;
    @(posedge clock); #1;
    bus.req_valid = 1; bus.req_addr = addr; bus.req_alloc = alloc;
    k = 0;
    do begin @(negedge clock); k++; end while (!bus.req_ready && k < 40);
    chk("req_accepted", bus.req_ready, 1);
    @(posedge clock); #1;
    bus.req_valid = 0;
    wait_rsp();
  endtask

  task automatic wait_sig_busy(input string nm);
    int k;
    k = 0;
    do begin @(negedge clock); k++; end while (!bus.flush_busy && k < 20);
    chk(nm, bus.flush_busy, 1);
  endtask

  task automatic wait_sig_done(input string nm);
    int k;
    k = 0;
    do begin @(negedge clock); k++; end while (!bus.flush_done && k < 20);
    chk(nm, bus.flush_done, 1);
  endtask

  logic [TW-1:0] tag_pool [4];

  initial begin
    int w0, d0, k, nrsp;
    bit busy_seen;
    bus.req_valid = 0; bus.req_addr = '0; bus.req_alloc = 0; bus.flush_req = 0;
    reset_n = 0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1;
    @(negedge clock);
    chk("reset_req_ready", bus.req_ready, 1);
    chk("reset_ram_we", bus.ram_we, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);

    // Power-up flush
    w0 = wr_cnt; d0 = done_cnt;
    @(posedge clock); #1 bus.flush_req = 1;
    wait_sig_busy("s1_busy");
    @(posedge clock); #1 bus.flush_req = 0;
    wait_sig_done("s1_done");
    chk("s1_ready_after", bus.req_ready, 1);
    @(posedge clock);
    chk("s1_write_count", wr_cnt - w0, 8);
    chk("s1_done_pulses", done_cnt - d0, 1);

    // Miss without allocation on a flushed entry
    do_req(16'h1235, 0);
    chk("s2_latency", r_lat, 3);
    chk("s2_hit", r_hit, 0);
    chk("s2_victim_valid", r_vv, 0);
    chk("s2_we_cycle3", r_we3, 0);

    // Allocating miss, then hit on the same address
    do_req(16'h1235, 1);
    chk("s3_latency", r_lat, 4);
    chk("s3_hit", r_hit, 0);
    chk("s3_we", r_we3, 1);
    chk("s3_addr", r_a3, 5);
    chk("s3_din", r_din3, 14'h2246);
    do_req(16'h1235, 0);
    chk("s3_hit_latency", r_lat, 3);
    chk("s3_hit2", r_hit, 1);
    chk("s3_index", r_idx, 5);

    // Replacement of a valid entry
    do_req(16'h5675, 1);
    chk("s4_hit", r_hit, 0);
    chk("s4_victim_valid", r_vv, 1);
    chk("s4_victim_tag", r_vt, 13'h246);
    chk("s4_din", r_din3, 14'h2ACE);
`ifdef TAG_LOOKUP_STATS_EN
    chk("s4_hit_count", hit_count, 1);
    chk("s4_miss_count", miss_count, 3);
`endif
    do_req(16'h1235, 0);
    chk("s4_relookup_hit", r_hit, 0);
    chk("s4_relookup_vtag", r_vt, 13'hACE);

    // Flush and request together: flush wins, request served afterwards
    @(posedge clock); #1;
    bus.flush_req = 1; bus.req_valid = 1; bus.req_addr = 16'h5675; bus.req_alloc = 0;
    wait_sig_busy("s5_busy");
    chk("s5_ready_low", bus.req_ready, 0);
    @(posedge clock); #1 bus.flush_req = 0;
    wait_sig_done("s5_done");
    chk("s5_ready_after", bus.req_ready, 1);
    @(posedge clock); #1 bus.req_valid = 0;
    wait_rsp();
    chk("s5_latency", r_lat, 3);
    chk("s5_hit", r_hit, 0);
    chk("s5_victim_valid", r_vv, 0);

    // Reset while in COMPARE
    @(posedge clock); #1;
    bus.req_valid = 1; bus.req_addr = 16'h1235; bus.req_alloc = 1;
    @(negedge clock);
    chk("s6_accept", bus.req_ready, 1);
    @(posedge clock); #1 bus.req_valid = 0;
    @(posedge clock); #1 reset_n = 0;
    #1;
    chk("s6_rsp_valid", bus.rsp_valid, 0);
    chk("s6_ram_we", bus.ram_we, 0);
    chk("s6_ram_addr", bus.ram_addr, 0);
    chk("s6_req_ready", bus.req_ready, 1);
    repeat (2) @(posedge clock);
    #1 reset_n = 1;
    nrsp = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (bus.rsp_valid || bus.ram_we) nrsp++;
    end
    chk("s6_no_activity", nrsp, 0);

    // Randomized traffic with a small tag pool so hits and replacements recur
    for (int i = 0; i < 4; i++) tag_pool[i] = TW'($urandom);
    busy_seen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #1;
      if (bus.flush_req && busy_seen) bus.flush_req = 0;
      else if (!bus.flush_req && $urandom_range(0, 149) == 0) bus.flush_req = 1;
      bus.req_valid = ($urandom_range(0, 3) != 0);
      bus.req_addr = {tag_pool[$urandom_range(0, 3)], AW'($urandom_range(0, 7))};
      bus.req_alloc = 1'($urandom_range(0, 1));
      @(negedge clock);
      busy_seen = bus.flush_busy;
    end
    @(posedge clock); #1;
    bus.req_valid = 0; bus.flush_req = 0;
    k = 0;
    repeat (20) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/tag_lookup_ctrl.md
Name: tag_lookup_ctrl

Overview:
Tag lookup/allocate controller sitting directly upstream of the synchronous-read tag RAM of the cache.
- Accepts a request address and splits it into index and tag.
- Issues the tag-RAM read and compares the returned entry against the request tag.
- Reports hit or miss; on an allocating miss, writes the new tag back with its valid bit set.
- Provides a flush sequencer that invalidates every entry after power-up or on demand.

Parameters:
- AWIDTH, 3: tag-RAM address width (index bits); DEPTH = 1<<AWIDTH.
- DWIDTH, 14: tag-RAM entry width. Bit DWIDTH-1 is the valid bit; bits DWIDTH-2:0 are the tag (TWIDTH = DWIDTH-1).

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  lookup request present
- req_ready  out  1  controller can accept a request
- req_addr  in  TWIDTH+AWIDTH  request address; tag = [TWIDTH+AWIDTH-1:AWIDTH], index = [AWIDTH-1:0]
- req_alloc  in  1  on a miss, allocate (write) the tag
- rsp_valid  out  1  single-cycle response strobe
- rsp_hit  out  1  1 = hit
- rsp_index  out  AWIDTH  index of the response
- rsp_victim_valid  out  1  valid bit of the entry read (meaningful on a miss)
- rsp_victim_tag  out  TWIDTH  tag of the entry read (meaningful on a miss)
- flush_req  in  1  start invalidating all entries
- flush_busy  out  1  flush in progress
- flush_done  out  1  single-cycle pulse after the last flush write
- ram_addr  out  AWIDTH  to tag RAM addr
- ram_din  out  DWIDTH  to tag RAM din
- ram_we  out  1  to tag RAM we
- ram_dout  in  DWIDTH  from tag RAM dout (valid one cycle after ram_addr is presented)

Behaviour:
- Reset is asynchronous and active-low (reset_n); clock is the single clock.
  - On reset: state IDLE; all outputs 0 except req_ready = 1; request registers and flush counter cleared.
  - Tag-RAM contents are not reset.
- States: IDLE, LOOKUP, COMPARE, FILL, FLUSH.
- IDLE:
  - req_ready = 1; ram_we = 0.
  - flush_req = 1 has priority: req_ready = 0 that cycle, go to FLUSH.
  - Otherwise req_valid & req_ready latches tag, index and alloc, then go to LOOKUP.
- LOOKUP: ram_addr = latched index; ram_we = 0; go to COMPARE.
- COMPARE:
  - hit = ram_dout[DWIDTH-1] & (ram_dout[DWIDTH-2:0] == tag).
  - rsp_victim_valid and rsp_victim_tag register from ram_dout.
  - If hit, or miss with alloc = 0: rsp_valid = 1 next cycle; go to IDLE.
  - If miss with alloc = 1: go to FILL.
- FILL:
  - ram_we = 1, ram_addr = index, ram_din = {1'b1, tag}.
  - rsp_valid = 1 next cycle with rsp_hit = 0; go to IDLE.
- Latency from the accept edge: hit or non-alloc miss gives rsp_valid in the 3rd cycle; allocating miss gives it in the 4th.
- Response handshake:
  - rsp_valid is high exactly one cycle; there is no backpressure.
  - req_ready is high in the same cycle as rsp_valid, so back-to-back requests are allowed.
- Response fields hold their values until the next response.
- RAM outputs (ram_addr, ram_din, ram_we) are 0 in IDLE.
- FLUSH:
  - Counter runs 0..DEPTH-1, one write per cycle: ram_we = 1, ram_addr = counter, ram_din = 0; flush_busy = 1.
  - After the write at DEPTH-1: flush_done pulses 1 cycle, counter wraps to 0, go to IDLE.
  - flush_req during FLUSH is ignored.
- A flush_req arriving outside IDLE is ignored; the requester holds it until flush_busy is seen.
- Read-after-write to the same index in consecutive requests returns the new entry; no bypass is needed.
- Reset mid-operation (any state) aborts immediately: no rsp_valid, no further RAM writes, flush incomplete.

Optional Feature:
TAG_LOOKUP_STATS_EN:
- Defined: adds outputs hit_count[15:0] and miss_count[15:0].
  - Each increments by 1 on every rsp_valid with hit or miss respectively, and saturates at 0xFFFF.
  - Both clear on reset and on entry to FLUSH.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
All scenarios use AWIDTH = 3, DWIDTH = 14; req_addr is 16 bits.
1. Reset, then flush_req: ram_we = 1 for 8 cycles with addr 0..7 and din 0x0000; flush_busy high throughout; flush_done pulses once; req_ready returns to 1.
2. After flush, req_addr = 0x1235 (tag 0x246, idx 5), alloc = 0: rsp_valid in cycle 3 with hit = 0, victim_valid = 0; no ram_we.
3. Same address, alloc = 1: cycle 3 has ram_we = 1, addr 5, din 0x2246; rsp_valid in cycle 4 with hit = 0. Repeat the lookup: hit = 1 in cycle 3, rsp_index = 5.
4. req_addr = 0x5675 (tag 0xACE, idx 5), alloc = 1: miss with victim_valid = 1, victim_tag = 0x246; the entry becomes 0x2ACE; a re-lookup of 0x1235 misses.
5. flush_req and req_valid asserted together in IDLE: flush wins and req_ready = 0 during the flush; the held request is accepted after flush_done and misses.
6. reset_n dropped during COMPARE: all outputs 0 immediately and no rsp_valid. With TAG_LOOKUP_STATS_EN, after scenarios 2–4: hit_count = 1, miss_count = 3.
